// File: rtl/svm_pkg.sv
// Shared types and helpers for the linear SVM classifier.
package svm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        OUTPUT = 2'd3
    } svm_state_e;

    // Width of an index into `value` entries, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// One class lane: weight/bias register file plus a signed multiply-accumulate.
module svm_mac_lane #(
    parameter int N_FEAT = 16,
    parameter int FEAT_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 22,
    parameter int IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [W_W-1:0]    wr_data,
    input  logic                     load,
    input  logic                     mac_en,
    input  logic [IDX_W-1:0]         feat_idx,
    input  logic signed [FEAT_W-1:0] feat_data,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = FEAT_W + W_W;

    // Entries 0..N_FEAT-1 are weights, entry N_FEAT is the bias.
    logic signed [W_W-1:0]    weight [N_FEAT+1];
    logic signed [W_W-1:0]    bias_now;
    logic signed [W_W-1:0]    weight_sel;
    logic signed [PROD_W-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= N_FEAT; i++) weight[i] <= '0;
        end else begin
            for (int i = 0; i <= N_FEAT; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) weight[i] <= wr_data;
            end
        end
    end

    // A bias written in the same cycle as the load is forwarded into the accumulator.
    assign bias_now   = (wr_en && wr_idx == IDX_W'(N_FEAT)) ? wr_data : weight[N_FEAT];
    assign weight_sel = weight[feat_idx];
    assign prod       = PROD_W'(feat_data) * PROD_W'(weight_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(bias_now);
        end else if (mac_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/svm_linear_classifier.sv
// Streaming linear SVM: per-class MAC lanes, then a serial arg-max (or sign in binary mode).
module svm_linear_classifier
    import svm_pkg::*;
#(
    parameter int N_FEAT  = 16,
    parameter int N_CLASS = 4,
    parameter int FEAT_W  = 8,
    parameter int W_W     = 8,
    localparam int ACC_W  = FEAT_W + W_W + $clog2(N_FEAT + 1) + 1,
    localparam int CLS_W  = clog2_min1(N_CLASS),
    localparam int IDX_W  = clog2_min1(N_FEAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    input  logic signed [FEAT_W-1:0] feat_data,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic                     wr_en,
    input  logic [CLS_W-1:0]         wr_class,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [W_W-1:0]    wr_data,
    output logic [CLS_W-1:0]         label,
    output logic signed [ACC_W-1:0]  score,
    output logic                     label_valid,
    input  logic                     label_ready,
    output svm_state_e               dbg_state
);

    // Handshakes: a feature moves on a cycle with feat_valid && feat_ready, a result
    // on a cycle with label_valid && label_ready; while valid is high the payload holds.

    svm_state_e               state, next_state;
    logic [IDX_W-1:0]         feat_cnt;
    logic [CLS_W-1:0]         cls_cnt;
    logic [CLS_W-1:0]         best_label;
    logic signed [ACC_W-1:0]  best_score;
    logic signed [ACC_W-1:0]  acc_sel;
    logic signed [ACC_W-1:0]  acc [N_CLASS];
    logic                     accept;
    logic                     feat_fire;
    logic                     feat_last;
    logic                     cls_last;
    logic                     wr_ok;

    assign accept    = (state == IDLE) && start;
    assign feat_fire = (state == ACCUM) && feat_valid;
    assign feat_last = (feat_cnt == IDX_W'(N_FEAT - 1));
    assign cls_last  = (cls_cnt == CLS_W'(N_CLASS - 1));
    assign wr_ok     = wr_en && (state == IDLE);
    assign acc_sel   = acc[cls_cnt];

    for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
        svm_mac_lane #(
            .N_FEAT (N_FEAT),
            .FEAT_W (FEAT_W),
            .W_W    (W_W),
            .ACC_W  (ACC_W),
            .IDX_W  (IDX_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_ok && (wr_class == CLS_W'(c))),
            .wr_idx    (wr_idx),
            .wr_data   (wr_data),
            .load      (accept),
            .mac_en    (feat_fire),
            .feat_idx  (feat_cnt),
            .feat_data (feat_data),
            .acc       (acc[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (feat_valid && feat_last) next_state = DECIDE;
            DECIDE:  if (cls_last) next_state = OUTPUT;
            OUTPUT:  if (label_valid && label_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        feat_ready = (state == ACCUM);
        dbg_state  = state;
    end

    // The first OUTPUT cycle copies the scan result into the held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_cnt    <= '0;
            cls_cnt     <= '0;
            best_label  <= '0;
            best_score  <= '0;
            label       <= '0;
            score       <= '0;
            label_valid <= 1'b0;
        end else begin
            if (feat_fire) feat_cnt <= feat_last ? '0 : feat_cnt + IDX_W'(1);
            if (state == DECIDE) begin
                cls_cnt <= cls_last ? '0 : cls_cnt + CLS_W'(1);
                if (N_CLASS == 1) begin
                    best_label <= CLS_W'(!acc_sel[ACC_W-1]);
                    best_score <= acc_sel;
                end else if (cls_cnt == '0 || acc_sel > best_score) begin
                    best_label <= cls_cnt;
                    best_score <= acc_sel;
                end
            end
            if (state == OUTPUT) begin
                if (!label_valid) begin
                    label       <= best_label;
                    score       <= best_score;
                    label_valid <= 1'b1;
                end else if (label_ready) begin
                    label_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_svm_linear_classifier.sv
// Directed bench: a 3-class DUT and a binary-mode DUT share one stimulus bus.
module tb_svm_linear_classifier;
    import svm_pkg::*;

    localparam int NF = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              feat_valid = 1'b0;
    logic              wr_en = 1'b0;
    logic              label_ready = 1'b0;
    logic signed [7:0] feat_data = '0;
    logic [1:0]        wr_class = '0;
    logic [2:0]        wr_idx = '0;
    logic signed [7:0] wr_data = '0;

    logic               busy, feat_ready, label_valid;
    logic [1:0]         label;
    logic signed [19:0] score;
    svm_state_e         dbg_state;

    logic               b_busy, b_feat_ready, b_label_valid;
    logic [0:0]         b_label;
    logic signed [19:0] b_score;
    svm_state_e         b_dbg_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int w0, w1, w2;
        int b0, b1, b2;
        int f0, f1, f2, f3;
        int exp_label;
        int exp_score;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    svm_linear_classifier #(.N_FEAT(NF), .N_CLASS(3), .FEAT_W(8), .W_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .wr_en(wr_en), .wr_class(wr_class), .wr_idx(wr_idx), .wr_data(wr_data),
        .label(label), .score(score), .label_valid(label_valid),
        .label_ready(label_ready), .dbg_state(dbg_state)
    );

    svm_linear_classifier #(.N_FEAT(NF), .N_CLASS(1), .FEAT_W(8), .W_W(8)) dut_bin (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy),
        .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(b_feat_ready),
        .wr_en(wr_en && !wr_class[1]), .wr_class(wr_class[0:0]), .wr_idx(wr_idx),
        .wr_data(wr_data), .label(b_label), .score(b_score),
        .label_valid(b_label_valid), .label_ready(label_ready), .dbg_state(b_dbg_state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_w(input int c, input int i, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_class = 2'(c); wr_idx = 3'(i); wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_class(input int c, input int w, input int b);
        for (int i = 0; i < NF; i++) write_w(c, i, w);
        write_w(c, NF, b);
    endtask

    task automatic start_and_feed(input int f0, input int f1, input int f2, input int f3,
                                  input bit cw, input int cw_data, input int nfeed);
        int f[4];
        f = '{f0, f1, f2, f3};
        @(negedge clk);
        start = 1'b1;
        if (cw) begin
            wr_en = 1'b1; wr_class = 2'd0; wr_idx = 3'(NF); wr_data = 8'(cw_data);
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < nfeed; i++) begin
            check("feat_ready", int'(feat_ready), 1);
            feat_valid = 1'b1; feat_data = 8'(f[i]);
            @(negedge clk);
        end
        feat_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit bin, output int lat);
        lat = 0;
        while (!(bin ? b_label_valid : label_valid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input bit bin);
        label_ready = 1'b1;
        @(negedge clk);
        check(bin ? "bin_busy_fall" : "busy_fall", int'(bin ? b_busy : busy), 0);
        for (int k = 0; k < 20 && (busy || b_busy); k++) @(negedge clk);
        check("both_idle", int'(busy | b_busy), 0);
        label_ready = 1'b0;
    endtask

    task automatic run_vec(input int f0, input int f1, input int f2, input int f3,
                           input bit bin, input bit cw, input int cw_data,
                           output int lat, output int lab, output int sc);
        start_and_feed(f0, f1, f2, f3, cw, cw_data, NF);
        wait_valid(bin, lat);
        lab = bin ? int'(b_label) : int'(label);
        sc  = bin ? int'(b_score) : int'(score);
        ack(bin);
    endtask

    initial begin
        int lat, lab, sc;

        vecs[0] = '{1, 2, -1,       0, 0, 0,       1, 2, 3, 4,           1, 20};
        vecs[1] = '{3, 3, 3,        0, 0, 0,       1, 1, 1, 1,           0, 12};
        vecs[2] = '{-128, -128, -128, 127, 127, 127, -128, -128, -128, -128, 0, 65663};
        vecs[3] = '{1, -1, 2,       0, 0, -3,      2, 2, 2, 2,           2, 13};
        vecs[4] = '{1, -1, 2,       5, 0, -3,      2, 2, 2, 2,           0, 13};
        vecs[5] = '{-1, -2, -3,     -1, -2, -3,    1, 1, 1, 1,           0, -5};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_feat_ready", int'(feat_ready), 0);
        check("rst_label_valid", int'(label_valid), 0);
        check("rst_label", int'(label), 0);
        check("rst_score", int'(score), 0);
        check("rst_bin_busy", int'(b_busy), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_class(0, vecs[v].w0, vecs[v].b0);
            load_class(1, vecs[v].w1, vecs[v].b1);
            load_class(2, vecs[v].w2, vecs[v].b2);
            run_vec(vecs[v].f0, vecs[v].f1, vecs[v].f2, vecs[v].f3, 1'b0, 1'b0, 0, lat, lab, sc);
            check($sformatf("v%0d_latency", v), lat, 4);
            check($sformatf("v%0d_label", v), lab, vecs[v].exp_label);
            check($sformatf("v%0d_score", v), sc, vecs[v].exp_score);
        end

        // Result held under back-pressure; start and weight write during OUTPUT are dropped.
        load_class(0, 1, 0);
        load_class(1, 2, 0);
        load_class(2, -1, 0);
        start_and_feed(1, 2, 3, 4, 1'b0, 0, NF);
        wait_valid(1'b0, lat);
        check("hold_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", int'(label_valid), 1);
            check("hold_label", int'(label), 1);
            check("hold_score", int'(score), 20);
            if (k == 1) begin
                start = 1'b1;
                wr_en = 1'b1; wr_class = 2'd0; wr_idx = 3'd0; wr_data = 8'sd50;
            end
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
        end
        ack(1'b0);
        @(negedge clk);
        check("start_ignored", int'(busy), 0);
        run_vec(1, 2, 3, 4, 1'b0, 1'b0, 0, lat, lab, sc);
        check("busy_write_dropped_label", lab, 1);
        check("busy_write_dropped_score", sc, 20);

        // Reset in the middle of a vector.
        start_and_feed(1, 2, 3, 4, 1'b0, 0, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_feat_ready", int'(feat_ready), 0);
        check("midrst_label_valid", int'(label_valid), 0);
        check("midrst_label", int'(label), 0);
        check("midrst_score", int'(score), 0);
        check("midrst_state", int'(dbg_state), int'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(1, 2, 3, 4, 1'b0, 1'b0, 0, lat, lab, sc);
        check("zero_w_latency", lat, 4);
        check("zero_w_label", lab, 0);
        check("zero_w_score", sc, 0);
        load_class(0, 1, 0);
        load_class(1, 2, 0);
        load_class(2, -1, 0);
        run_vec(1, 2, 3, 4, 1'b0, 1'b0, 0, lat, lab, sc);
        check("post_rst_latency", lat, 4);
        check("post_rst_label", lab, 1);
        check("post_rst_score", sc, 20);

        // Binary mode; later biases are written in the same cycle as start.
        load_class(0, -1, 5);
        run_vec(1, 1, 1, 1, 1'b1, 1'b0, 0, lat, lab, sc);
        check("bin_pos_latency", lat, 2);
        check("bin_pos_label", lab, 1);
        check("bin_pos_score", sc, 1);
        write_w(1, 0, 100);
        run_vec(1, 1, 1, 1, 1'b1, 1'b1, 3, lat, lab, sc);
        check("bin_neg_latency", lat, 2);
        check("bin_neg_label", lab, 0);
        check("bin_neg_score", sc, -1);
        run_vec(1, 1, 1, 1, 1'b1, 1'b1, 4, lat, lab, sc);
        check("bin_zero_label", lab, 1);
        check("bin_zero_score", sc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/svm_linear_classifier.md
SVM_LINEAR_CLASSIFIER -- requirements
Module: svm_linear_classifier

Interface
REQ-001 Parameter N_FEAT, default 16: feature-vector length, at least 1.
REQ-002 Parameter N_CLASS, default 4: class count; a value of 1 selects binary (sign) mode.
REQ-003 Parameter FEAT_W, default 8: signed feature width.
REQ-004 Parameter W_W, default 8: signed weight and bias width.
REQ-005 Derived ACC_W = FEAT_W+W_W+$clog2(N_FEAT+1)+1, signed score width; not user-overridable.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle request to classify one vector.
REQ-009 busy  out  1  high from start acceptance until the label handshake completes.
REQ-010 feat_data  in  FEAT_W  signed feature, streamed in index order 0..N_FEAT-1.
REQ-011 feat_valid/feat_ready  in/out  1 each  feature handshake; transfer when both are high.
REQ-012 wr_en  in  1  weight/bias write strobe.
REQ-013 wr_class  in  clog2(N_CLASS)  target class (min 1 bit).
REQ-014 wr_idx  in  clog2(N_FEAT+1)  feature index; the value N_FEAT addresses the bias.
REQ-015 wr_data  in  W_W  signed weight or bias.
REQ-016 label  out  clog2(N_CLASS) (min 1)  winning class, or in binary mode 1 = positive.
REQ-017 score  out  ACC_W  winning class score, including bias.
REQ-018 label_valid/label_ready  out/in  1 each  result handshake.

Function
REQ-019 FSM states SHALL be IDLE, ACCUM, DECIDE, OUTPUT; reset state is IDLE.
REQ-020 IDLE->ACCUM on start; every accumulator SHALL load its class bias; start outside IDLE is ignored.
REQ-021 In ACCUM, feat_ready=1; each transfer adds feat_data*weight[c][i] to acc[c] for all classes in parallel; no stalls when feat_valid stays high.
REQ-022 After the N_FEAT-th transfer, the FSM SHALL move ACCUM->DECIDE; the feature counter resets to 0.
REQ-023 DECIDE SHALL scan classes 0..N_CLASS-1 at one class per cycle, keeping the running maximum; the maximum updates only on a strictly greater score, so ties go to the lowest index.
REQ-024 In binary mode, DECIDE lasts 1 cycle: label = (acc[0] >= 0), score = acc[0].
REQ-025 label_valid SHALL rise exactly N_CLASS+1 cycles after the final feature handshake (2 cycles in binary mode).
REQ-026 In OUTPUT, label, score and label_valid SHALL hold stable until label_ready; the handshake cycle returns the FSM to IDLE and busy falls in the next cycle.
REQ-027 Arithmetic is full-precision signed; no saturation or overflow is possible at ACC_W.
REQ-028 Weight writes are accepted only in IDLE, with a 1-cycle write latency; writes while busy are dropped; an out-of-range wr_class or wr_idx is dropped.
REQ-029 start coincident with wr_en in IDLE: the write SHALL complete and the new value is used by this classification.
REQ-030 feat_ready=0 outside ACCUM; feat_valid outside ACCUM is ignored.

Reset
REQ-031 When rst_n goes low (including mid-operation), the FSM SHALL go to IDLE and counters and accumulators clear; busy, feat_ready, label_valid, label and score are 0.
REQ-032 Weight/bias storage SHALL reset to 0.
REQ-033 Deassertion is synchronized externally; the first start after reset behaves normally.

Structure
REQ-034 Shared package svm_pkg SHALL hold the FSM state enum and a width-helper function for clog2 with a minimum of 1.
REQ-035 One sub-module, svm_mac_lane, SHALL be instantiated N_CLASS times; each lane holds that class's weight/bias registers and its accumulator.

Verification (N_FEAT=4, N_CLASS=3, FEAT_W=W_W=8 unless stated)
REQ-036 Weights c0=all 1, c1=all 2, c2=all -1, biases 0; features 1,2,3,4 -> label=1, score=20, label_valid 4 cycles after the last feature.
REQ-037 All classes with identical weights of 3 and bias 0; features 1,1,1,1 -> label=0, score=12 (tie rule).
REQ-038 Case REQ-036 with label_ready low for 5 cycles -> label/score/label_valid stable for all 5 cycles; a start pulsed during that time is ignored.
REQ-039 N_CLASS=1, weights all -1, bias 5; features 1,1,1,1 -> label=1, score=1; with bias 3 -> label=0, score=-1.
REQ-040 Features all -128, weights all -128, bias 127 -> score=65663 exact, no overflow.
REQ-041 rst_n pulsed low after 2 features -> all outputs 0 and weights 0; reload the REQ-036 weights, rerun -> label=1, score=20.
